// File: rtl/bakraid_clk_pkg.sv
// Shared definitions for the Bakraid clock-tree enable monitors.
package bakraid_clk_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mon_state_e;

  // 1 ms of CLK96
  localparam int DEFAULT_WINDOW = 96000;

  // Expected pulses per 1 ms window for each generated enable
  localparam logic [15:0] EXP_CNT_6M75   = 16'd6750;
  localparam logic [15:0] EXP_CNT_13M5   = 16'd13500;
  localparam logic [15:0] EXP_CNT_5M333  = 16'd5333;
  localparam logic [15:0] EXP_CNT_16M934 = 16'd16934;

endpackage

// File: rtl/bakraid_cen_gap.sv
// CEN-to-CEN gap tracker: saturating gap counter, arm flag and per-window min/max.
module bakraid_cen_gap #(
  parameter int GW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          run,
  input  logic          cen,
  input  logic          restart,
  output logic [GW-1:0] min_gap,
  output logic [GW-1:0] max_gap
);

  localparam logic [GW-1:0] ONES = '1;

  logic [GW-1:0] gap_q;
  logic [GW-1:0] min_q;
  logic [GW-1:0] max_q;
  logic [GW-1:0] min_nxt;
  logic [GW-1:0] max_nxt;
  logic [1:0]    ngap_q;
  logic [1:0]    ngap_nxt;
  logic          armed_q;
  logic          hit;

  // Min/max including this cycle's gap, so the top can latch on the last window cycle
  always_comb begin
    hit      = run & cen & armed_q;
    min_nxt  = (hit && (gap_q < min_q)) ? gap_q : min_q;
    max_nxt  = (hit && (gap_q > max_q)) ? gap_q : max_q;
    ngap_nxt = (hit && (ngap_q != 2'd2)) ? ngap_q + 2'd1 : ngap_q;
    min_gap  = (ngap_nxt == 2'd2) ? min_nxt : ONES;
    max_gap  = (ngap_nxt == 2'd2) ? max_nxt : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q   <= '0;
      armed_q <= 1'b0;
      min_q   <= ONES;
      max_q   <= '0;
      ngap_q  <= 2'd0;
    end else if (clear) begin
      gap_q   <= '0;
      armed_q <= 1'b0;
      min_q   <= ONES;
      max_q   <= '0;
      ngap_q  <= 2'd0;
    end else if (run) begin
      // Gap continuity deliberately survives the window restart
      if (cen) begin
        gap_q   <= GW'(1);
        armed_q <= 1'b1;
      end else if (gap_q != ONES) begin
        gap_q <= gap_q + GW'(1);
      end
      if (restart) begin
        min_q  <= ONES;
        max_q  <= '0;
        ngap_q <= 2'd0;
      end else begin
        min_q  <= min_nxt;
        max_q  <= max_nxt;
        ngap_q <= ngap_nxt;
      end
    end
  end

endmodule

// File: rtl/bakraid_cen_monitor.sv
// Windowed rate / gap / overlap monitor for one fractional clock-enable strobe.
module bakraid_cen_monitor
  import bakraid_clk_pkg::*;
#(
  parameter int WINDOW = DEFAULT_WINDOW,
  parameter int CW     = 16,
  parameter int GW     = 8
) (
  input  logic          CLK96,
  input  logic          RESETn,
  input  logic          ENABLE,
  input  logic          CEN,
  input  logic          CENB,
  input  logic [CW-1:0] EXP_COUNT,
  input  logic [7:0]    TOL,
  output logic [CW-1:0] COUNT,
  output logic [GW-1:0] MIN_GAP,
  output logic [GW-1:0] MAX_GAP,
  output logic          VALID,
  output logic          RATE_OK,
  output logic          OVERLAP
);

  localparam int            WCW  = $clog2(WINDOW);
  localparam logic [WCW-1:0] LAST = WCW'(WINDOW - 1);

  mon_state_e    state_q;
  logic [WCW-1:0] win_q;
  logic [CW-1:0]  pulse_q;
  logic [CW-1:0]  pulse_nxt;
  logic [GW-1:0]  gmin;
  logic [GW-1:0]  gmax;
  logic           enter;
  logic           run;
  logic           last;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // Difference is CW+1 bits signed so |count - expected| never wraps
  function automatic logic within_tol(input logic [CW-1:0] cnt,
                                      input logic [CW-1:0] expv,
                                      input logic [7:0]    tol);
    logic signed [CW:0] d;
    logic [CW:0]        mag;
    d   = $signed({1'b0, cnt}) - $signed({1'b0, expv});
    mag = d[CW] ? $unsigned(-d) : $unsigned(d);
    return ({8'd0, mag} <= {{(CW+1){1'b0}}, tol});
  endfunction

  always_comb begin
    enter     = (state_q == IDLE) && ENABLE;
    run       = (state_q == RUN) && ENABLE;
    last      = run && (win_q == LAST);
    pulse_nxt = CEN ? sat_inc(pulse_q) : pulse_q;
  end

  bakraid_cen_gap #(
    .GW (GW)
  ) u_gap (
    .clk     (CLK96),
    .rst_n   (RESETn),
    .clear   (enter),
    .run     (run),
    .cen     (CEN),
    .restart (last),
    .min_gap (gmin),
    .max_gap (gmax)
  );

  always_ff @(posedge CLK96 or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      win_q   <= '0;
      pulse_q <= '0;
      COUNT   <= '0;
      MIN_GAP <= '1;
      MAX_GAP <= '0;
      VALID   <= 1'b0;
      RATE_OK <= 1'b0;
      OVERLAP <= 1'b0;
    end else begin
      VALID   <= 1'b0;
      state_q <= ENABLE ? RUN : IDLE;
      if (enter)
        OVERLAP <= 1'b0;
      else if ((state_q == RUN) && CEN && CENB)
        OVERLAP <= 1'b1;
      // Dropping ENABLE, even on the last cycle, discards the window
      if (run) begin
        if (last) begin
          win_q   <= '0;
          pulse_q <= '0;
          COUNT   <= pulse_nxt;
          MIN_GAP <= gmin;
          MAX_GAP <= gmax;
          RATE_OK <= within_tol(pulse_nxt, EXP_COUNT, TOL);
          VALID   <= 1'b1;
        end else begin
          win_q   <= win_q + WCW'(1);
          pulse_q <= pulse_nxt;
        end
      end else begin
        win_q   <= '0;
        pulse_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bakraid_cen_monitor.sv
// Directed bench for bakraid_cen_monitor with a short 1280-cycle window.
module tb_bakraid_cen_monitor;

  localparam int WIN = 1280;
  localparam int CW  = 16;
  localparam int GW  = 8;

  logic          CLK96 = 1'b0;
  logic          RESETn;
  logic          ENABLE;
  logic          CEN;
  logic          CENB;
  logic [CW-1:0] EXP_COUNT;
  logic [7:0]    TOL;
  logic [CW-1:0] COUNT;
  logic [GW-1:0] MIN_GAP;
  logic [GW-1:0] MAX_GAP;
  logic          VALID;
  logic          RATE_OK;
  logic          OVERLAP;

  int tests = 0;
  int fails = 0;

  bakraid_cen_monitor #(.WINDOW(WIN), .CW(CW), .GW(GW)) dut (
    .CLK96     (CLK96),
    .RESETn    (RESETn),
    .ENABLE    (ENABLE),
    .CEN       (CEN),
    .CENB      (CENB),
    .EXP_COUNT (EXP_COUNT),
    .TOL       (TOL),
    .COUNT     (COUNT),
    .MIN_GAP   (MIN_GAP),
    .MAX_GAP   (MAX_GAP),
    .VALID     (VALID),
    .RATE_OK   (RATE_OK),
    .OVERLAP   (OVERLAP)
  );

  always #5 CLK96 = ~CLK96;

  task automatic tick();
    @(posedge CLK96);
    #1;
  endtask

  // Leaves the bench just after the edge that enters RUN; next tick samples cycle 0
  task automatic enter_run();
    CEN = 1'b0; CENB = 1'b0; ENABLE = 1'b0;
    tick();
    ENABLE = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RESETn = 1'b0; ENABLE = 1'b0; CEN = 1'b0; CENB = 1'b0;
    EXP_COUNT = '0; TOL = '0;
    repeat (3) tick();
    tests++; if (COUNT !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", COUNT); end
    tests++; if (MIN_GAP !== 8'hFF) begin fails++; $display("FAIL reset_min: got %0d want 255", MIN_GAP); end
    tests++; if (MAX_GAP !== 8'd0) begin fails++; $display("FAIL reset_max: got %0d want 0", MAX_GAP); end
    tests++; if (VALID !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", VALID); end
    tests++; if (RATE_OK !== 1'b0) begin fails++; $display("FAIL reset_rate: got %b want 0", RATE_OK); end
    tests++; if (OVERLAP !== 1'b0) begin fails++; $display("FAIL reset_overlap: got %b want 0", OVERLAP); end
    RESETn = 1'b1;
    tick();
  endtask

  task automatic test_ideal_6m75();
    int acc = 0;
    int spur = 0;
    EXP_COUNT = 16'd90; TOL = 8'd1;
    enter_run();
    for (int k = 0; k < 2*WIN; k++) begin
      acc += 9;
      CEN = (acc >= 128);
      if (acc >= 128) acc -= 128;
      tick();
      if (k % WIN == WIN-1) begin
        tests++; if (VALID !== 1'b1) begin fails++; $display("FAIL ideal_valid: got %b want 1 at k=%0d", VALID, k); end
        tests++; if (COUNT !== 16'd90) begin fails++; $display("FAIL ideal_count: got %0d want 90", COUNT); end
        tests++; if (MIN_GAP !== 8'd14) begin fails++; $display("FAIL ideal_min: got %0d want 14", MIN_GAP); end
        tests++; if (MAX_GAP !== 8'd15) begin fails++; $display("FAIL ideal_max: got %0d want 15", MAX_GAP); end
        tests++; if (RATE_OK !== 1'b1) begin fails++; $display("FAIL ideal_rate: got %b want 1", RATE_OK); end
        tests++; if (OVERLAP !== 1'b0) begin fails++; $display("FAIL ideal_overlap: got %b want 0", OVERLAP); end
      end else if (VALID !== 1'b0) spur++;
    end
    CEN = 1'b0;
    tests++; if (spur != 0) begin fails++; $display("FAIL ideal_spurious_valid: got %0d want 0", spur); end
  endtask

  task automatic test_frac_16m93();
    int acc = 0;
    int spur = 0;
    int w = 0;
    int total = 0;
    int expc [5] = '{225, 226, 226, 226, 225};
    EXP_COUNT = 16'd225; TOL = 8'd1;
    enter_run();
    for (int k = 0; k < 5*WIN; k++) begin
      acc += 441;
      CEN = (acc >= 2500);
      if (acc >= 2500) acc -= 2500;
      tick();
      if (k % WIN == WIN-1) begin
        total += int'(COUNT);
        tests++; if (COUNT !== CW'(expc[w])) begin fails++; $display("FAIL frac_count: got %0d want %0d (window %0d)", COUNT, expc[w], w); end
        tests++; if (MIN_GAP !== 8'd5 || MAX_GAP !== 8'd6) begin fails++; $display("FAIL frac_gaps: got %0d/%0d want 5/6", MIN_GAP, MAX_GAP); end
        tests++; if (RATE_OK !== 1'b1 || VALID !== 1'b1) begin fails++; $display("FAIL frac_rate_valid: got %b/%b want 1/1", RATE_OK, VALID); end
        w++;
      end else if (VALID !== 1'b0) spur++;
    end
    CEN = 1'b0;
    tests++; if (total != 1128) begin fails++; $display("FAIL frac_total: got %0d want 1128", total); end
    tests++; if (spur != 0) begin fails++; $display("FAIL frac_spurious_valid: got %0d want 0", spur); end
  endtask

  task automatic test_rate_fail();
    int spur = 0;
    EXP_COUNT = 16'd100; TOL = 8'd5;
    enter_run();
    for (int k = 0; k < 2*WIN; k++) begin
      CEN = (k % 20 == 19);
      tick();
      if (k % WIN == WIN-1) begin
        tests++; if (COUNT !== 16'd64) begin fails++; $display("FAIL slow_count: got %0d want 64", COUNT); end
        tests++; if (MIN_GAP !== 8'd20 || MAX_GAP !== 8'd20) begin fails++; $display("FAIL slow_gaps: got %0d/%0d want 20/20", MIN_GAP, MAX_GAP); end
        tests++; if (RATE_OK !== 1'b0) begin fails++; $display("FAIL slow_rate: got %b want 0", RATE_OK); end
      end else if (VALID !== 1'b0) spur++;
    end
    CEN = 1'b0;
    tests++; if (spur != 0) begin fails++; $display("FAIL slow_spurious_valid: got %0d want 0", spur); end
  endtask

  task automatic test_tol_edge();
    logic [CW-1:0] expv [4] = '{16'd59, 16'd58, 16'd69, 16'd70};
    logic          want [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    TOL = 8'd5;
    enter_run();
    for (int k = 0; k < 4*WIN; k++) begin
      if (k % WIN == 0) EXP_COUNT = expv[k / WIN];
      CEN = (k % 20 == 19);
      tick();
      if (k % WIN == WIN-1) begin
        tests++; if (RATE_OK !== want[k / WIN] || VALID !== 1'b1) begin
          fails++; $display("FAIL tol_edge: got rate %b valid %b want %b/1 (exp %0d)", RATE_OK, VALID, want[k / WIN], EXP_COUNT);
        end
      end
    end
    CEN = 1'b0;
  endtask

  task automatic test_overlap();
    EXP_COUNT = 16'd64; TOL = 8'd0;
    enter_run();
    for (int k = 0; k < 2*WIN; k++) begin
      CEN  = (k % 20 == 19);
      CENB = (k % 20 == 9) || (k == 299);
      tick();
      if (k == 298) begin
        tests++; if (OVERLAP !== 1'b0) begin fails++; $display("FAIL overlap_early: got %b want 0", OVERLAP); end
      end
      if (k % WIN == WIN-1) begin
        tests++; if (OVERLAP !== 1'b1) begin fails++; $display("FAIL overlap_sticky: got %b want 1 at k=%0d", OVERLAP, k); end
        tests++; if (RATE_OK !== 1'b1) begin fails++; $display("FAIL overlap_rate: got %b want 1", RATE_OK); end
      end
    end
    CEN = 1'b0; CENB = 1'b0; ENABLE = 1'b0;
    tick();
    tests++; if (OVERLAP !== 1'b1) begin fails++; $display("FAIL overlap_idle_hold: got %b want 1", OVERLAP); end
    ENABLE = 1'b1;
    tick();
    tests++; if (OVERLAP !== 1'b0) begin fails++; $display("FAIL overlap_reentry_clear: got %b want 0", OVERLAP); end
  endtask

  task automatic test_disable();
    int spur = 0;
    EXP_COUNT = 16'd64; TOL = 8'd0;
    enter_run();
    for (int k = 0; k < WIN + 500; k++) begin
      CEN = (k % 20 == 19);
      tick();
      if (k == WIN-1) begin
        tests++; if (VALID !== 1'b1 || COUNT !== 16'd64) begin fails++; $display("FAIL dis_first: got valid %b count %0d want 1/64", VALID, COUNT); end
      end else if (VALID !== 1'b0) spur++;
    end
    ENABLE = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      CEN = (k % 10 == 9);
      tick();
      if (VALID !== 1'b0) spur++;
    end
    tests++; if (spur != 0) begin fails++; $display("FAIL dis_spurious_valid: got %0d want 0", spur); end
    tests++; if (COUNT !== 16'd64 || MIN_GAP !== 8'd20 || MAX_GAP !== 8'd20 || RATE_OK !== 1'b1) begin
      fails++; $display("FAIL dis_hold: got %0d/%0d/%0d/%b want 64/20/20/1", COUNT, MIN_GAP, MAX_GAP, RATE_OK);
    end
    CEN = 1'b0; ENABLE = 1'b1;
    tick();
    for (int k = 0; k < WIN; k++) begin
      CEN = (k % 10 == 9);
      tick();
      if (k == WIN-1) begin
        tests++; if (VALID !== 1'b1) begin fails++; $display("FAIL dis_reenable_valid: got %b want 1", VALID); end
        tests++; if (COUNT !== 16'd128 || MIN_GAP !== 8'd10 || MAX_GAP !== 8'd10 || RATE_OK !== 1'b0) begin
          fails++; $display("FAIL dis_reenable_result: got %0d/%0d/%0d/%b want 128/10/10/0", COUNT, MIN_GAP, MAX_GAP, RATE_OK);
        end
      end else if (VALID !== 1'b0) spur++;
    end
    CEN = 1'b0;
    tests++; if (spur != 0) begin fails++; $display("FAIL dis_reenable_spurious: got %0d want 0", spur); end
  endtask

  task automatic test_last_cycle_drop();
    int seen = 0;
    enter_run();
    for (int k = 0; k < WIN-1; k++) begin
      CEN = (k % 20 == 19);
      tick();
    end
    ENABLE = 1'b0; CEN = 1'b1;
    tick();
    tests++; if (VALID !== 1'b0) begin fails++; $display("FAIL drop_last_valid: got %b want 0", VALID); end
    CEN = 1'b0;
    repeat (4) begin
      tick();
      if (VALID !== 1'b0) seen++;
    end
    tests++; if (seen != 0 || COUNT !== 16'd128 || MIN_GAP !== 8'd10) begin
      fails++; $display("FAIL drop_last_hold: got valids %0d count %0d min %0d want 0/128/10", seen, COUNT, MIN_GAP);
    end
  endtask

  task automatic test_async_reset();
    int spur = 0;
    EXP_COUNT = 16'd64; TOL = 8'd0;
    enter_run();
    for (int k = 0; k < WIN + 300; k++) begin
      CEN  = (k % 20 == 19);
      CENB = (k == 59);
      tick();
    end
    CEN = 1'b0; CENB = 1'b0;
    tests++; if (COUNT !== 16'd64 || OVERLAP !== 1'b1 || RATE_OK !== 1'b1) begin
      fails++; $display("FAIL areset_pre: got %0d/%b/%b want 64/1/1", COUNT, OVERLAP, RATE_OK);
    end
    #2 RESETn = 1'b0;
    #1;
    tests++; if (COUNT !== 16'd0 || MIN_GAP !== 8'hFF || MAX_GAP !== 8'd0) begin
      fails++; $display("FAIL areset_results: got %0d/%0d/%0d want 0/255/0", COUNT, MIN_GAP, MAX_GAP);
    end
    tests++; if (VALID !== 1'b0 || RATE_OK !== 1'b0 || OVERLAP !== 1'b0) begin
      fails++; $display("FAIL areset_flags: got %b/%b/%b want 0/0/0", VALID, RATE_OK, OVERLAP);
    end
    #1 RESETn = 1'b1;
    tick();
    for (int k = 0; k < WIN; k++) begin
      CEN = (k % 20 == 19);
      tick();
      if (k == WIN-1) begin
        tests++; if (VALID !== 1'b1 || COUNT !== 16'd64) begin fails++; $display("FAIL areset_restart: got valid %b count %0d want 1/64", VALID, COUNT); end
      end else if (VALID !== 1'b0) spur++;
    end
    CEN = 1'b0;
    tests++; if (spur != 0) begin fails++; $display("FAIL areset_spurious: got %0d want 0", spur); end
  endtask

  task automatic test_sparse();
    EXP_COUNT = 16'd2; TOL = 8'd0;
    enter_run();
    for (int k = 0; k < 2*WIN; k++) begin
      CEN = (k == 100) || (k == 130) || (k == 1380) || (k == 1420);
      tick();
      if (k == WIN-1) begin
        tests++; if (COUNT !== 16'd2 || MIN_GAP !== 8'hFF || MAX_GAP !== 8'd0 || RATE_OK !== 1'b1) begin
          fails++; $display("FAIL sparse_one_gap: got %0d/%0d/%0d/%b want 2/255/0/1", COUNT, MIN_GAP, MAX_GAP, RATE_OK);
        end
      end
      if (k == 2*WIN-1) begin
        tests++; if (COUNT !== 16'd2 || MIN_GAP !== 8'd40 || MAX_GAP !== 8'd255) begin
          fails++; $display("FAIL sparse_sat_gap: got %0d/%0d/%0d want 2/40/255", COUNT, MIN_GAP, MAX_GAP);
        end
      end
    end
    CEN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ideal_6m75();
    test_frac_16m93();
    test_rate_fail();
    test_tol_edge();
    test_overlap();
    test_disable();
    test_last_cycle_drop();
    test_async_reset();
    test_sparse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bakraid_cen_monitor.md
# bakraid_cen_monitor

Self-checking consumer of the fractional clock-enable strobes in the Bakraid clock tree: it counts enable pulses per fixed window of `CLK96` cycles, measures inter-pulse gaps, and flags rate and `CEN`/`CENB` overlap errors. One instance sits beside each generated enable (GP9001, Z80, YMZ280B), and its outputs go to debug registers and the sim bench. It does not gate or modify the enables.

## Interface
Parameters:
- `WINDOW`, 96000: window length in `CLK96` cycles (1 ms at 96 MHz); must be ≥ 2.
- `CW`, 16: pulse-count width.
- `GW`, 8: gap-counter width.

Ports:
- `CLK96`  in  1  sole clock, 96 MHz.
- `RESETn`  in  1  asynchronous, active-low reset.
- `ENABLE`  in  1  high = measure; low = idle, counters cleared, results held.
- `CEN`  in  1  enable strobe under test, `CLK96` domain.
- `CENB`  in  1  companion strobe (half-period offset).
- `EXP_COUNT`  in  CW  expected pulses per window.
- `TOL`  in  8  allowed |count − expected|.
- `COUNT`  out  CW  pulses counted in the last completed window.
- `MIN_GAP`, `MAX_GAP`  out  GW  smallest/largest `CEN`-to-`CEN` distance in the last window, in cycles.
- `VALID`  out  1  one-cycle strobe: results updated.
- `RATE_OK`  out  1  last window within tolerance.
- `OVERLAP`  out  1  sticky: `CEN` and `CENB` were high in the same cycle.

## Operation
- States: `IDLE`, `RUN`. Reset enters `IDLE`. `ENABLE`=1 in `IDLE` moves to `RUN` on the next edge. `ENABLE`=0 in any state returns to `IDLE` on the next edge and discards the partial window.
- Entering `RUN` clears the window counter, the pulse counter, the gap tracker and `OVERLAP`. The window runs `WINDOW` cycles. Cycle 0 is the first cycle in `RUN`.
- Pulse counter: +1 per cycle with `CEN`=1, saturating at all-ones.
- Gap tracker:
  - The gap counter increments every `RUN` cycle and saturates at 2^GW−1.
  - On `CEN`, if a previous `CEN` has been seen, the gap is (cycles since previous `CEN`). Example: pulses on cycles 10 and 24 give gap 14. Min/max are updated, then the counter restarts.
  - The first `CEN` after entering `RUN` only arms the tracker.
  - Gap continuity carries across window boundaries. Min/max restart at each window (min = all-ones, max = 0).
- On the last window cycle (counter = `WINDOW`−1):
  - `COUNT`, `MIN_GAP` and `MAX_GAP` latch the values including that cycle's `CEN`.
  - `RATE_OK` latches (|COUNT − EXP_COUNT| ≤ TOL), computed as a CW+1-bit signed difference.
  - The next window starts with no idle cycle.
- A window with fewer than 2 gaps reports `MIN_GAP` all-ones and `MAX_GAP` 0.
- `OVERLAP` is set on any `RUN` cycle with `CEN`&`CENB`. It stays set until the next entry into `RUN` or reset.

## Timing
- Reset values: `COUNT`=0, `MIN_GAP`=all-ones, `MAX_GAP`=0, `VALID`=0, `RATE_OK`=0, `OVERLAP`=0, state `IDLE`.
- `VALID` pulses exactly one cycle: the cycle after the window's last cycle, i.e. `WINDOW` cycles after `RUN` entry, then every `WINDOW` cycles. Result outputs change on the same edge that raises `VALID` and are stable until the next `VALID`.
- Inputs are sampled at the clock edge with no input synchronisers. `CEN`/`CENB` come from the same `CLK96` domain.
- Simultaneous events:
  - `ENABLE` falling on the last window cycle: no latch and no `VALID`. `IDLE` wins.
  - `CEN` on the last cycle together with a window restart: counted in the old window. Its gap is recorded in the old window's min/max.
- Asserting `RESETn` mid-window forces the reset values immediately (asynchronous) and discards the window.

## Structure
- Shared package `bakraid_clk_pkg` holds:
  - the state enum (`IDLE`, `RUN`);
  - the default `WINDOW`;
  - expected-count constants per enable: 6750, 13500, 5333, 16934.
- One sub-module, `bakraid_cen_gap`, implements the gap counter, arm flag and min/max, with a window-restart input. The top holds the state, the window/pulse counters, compare and latching.

## Test plan
- Ideal 6.75 MHz source (the 9/128 fractional enable, n=9, m=128 on `CLK96`), `WINDOW`=96000, `EXP_COUNT`=6750, `TOL`=1 -> `VALID` at cycle 96000 after enable; `COUNT`=6750, `MIN_GAP`=14, `MAX_GAP`=15, `RATE_OK`=1, `OVERLAP`=0.
- 16.9344 MHz source (441/2500), `EXP_COUNT`=16934, `TOL`=1 -> `COUNT` ∈ {16934, 16935}, gaps 5/6, `RATE_OK`=1 on every window over 5 windows.
- `CEN` every 20 cycles, `WINDOW`=1000, `EXP_COUNT`=100, `TOL`=5 -> `COUNT`=50, `MIN_GAP`=`MAX_GAP`=20, `RATE_OK`=0.
- `CENB` forced equal to `CEN` for one cycle -> `OVERLAP`=1 and it persists across windows. `ENABLE` toggled low/high -> `OVERLAP`=0.
- `ENABLE` dropped at cycle 500 of a 1000-cycle window -> no `VALID`, outputs keep prior values. Re-enable -> first `VALID` 1000 cycles later.
- `RESETn` pulsed low mid-window (asynchronous, between edges) -> all outputs immediately return to reset values, state `IDLE`.
